// File: rtl/adiabatic_pkg.sv
// Shared types and helpers for the adiabatic power-clock sequencer.
// Imported by adiabatic_pclk_gen and adiabatic_pclk_phase.
package adiabatic_pkg;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUN     = 2'd1,
      DRAIN   = 2'd2
   } pclk_state_e;

   typedef enum logic [1:0] {
      RAMP_UP = 2'd0,
      HOLD    = 2'd1,
      RAMP_DN = 2'd2,
      IDLE    = 2'd3
   } interval_e;

   localparam int unsigned IntvW = 2;

   function automatic int unsigned level_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/adiabatic_pclk_phase.sv
// One trapezoidal power-clock phase: tracks its active flag and registers the
// level code plus the clkpos/clkneg pair for the current interval.
module adiabatic_pclk_phase
   import adiabatic_pkg::*;
#(
   parameter int unsigned LEVEL_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LEVEL_W-1:0] sub,
   input  interval_e          p_i,
   input  logic               drain,
   output logic               active,
   output logic [LEVEL_W-1:0] level,
   output logic               clkpos,
   output logic               clkneg
);

   localparam logic [LEVEL_W-1:0] MaxLvl = LEVEL_W'(level_max(LEVEL_W));

   logic               active_q, active_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               clkpos_q, clkpos_d;
   logic               clkneg_q, clkneg_d;
   logic [LEVEL_W-1:0] ramp;

   always_comb begin
      ramp = '0;
      unique case (p_i)
         RAMP_UP: ramp = sub;
         HOLD:    ramp = MaxLvl;
         RAMP_DN: ramp = MaxLvl - sub;
         IDLE:    ramp = '0;
      endcase
   end

   always_comb begin
      active_d = active_q;
      if (drain) begin
         // Idle ends the pulse; a fresh ramp-up is never started while draining.
         if ((p_i == IDLE) || (p_i == RAMP_UP)) begin
            active_d = 1'b0;
         end
      end else if (p_i == RAMP_UP) begin
         active_d = 1'b1;
      end

      level_d  = active_d ? ramp : '0;
      clkpos_d = active_d & ramp[LEVEL_W-1];
      clkneg_d = active_d & ~ramp[LEVEL_W-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         level_q  <= '0;
         clkpos_q <= 1'b0;
         clkneg_q <= 1'b0;
      end else begin
         active_q <= active_d;
         level_q  <= level_d;
         clkpos_q <= clkpos_d;
         clkneg_q <= clkneg_d;
      end
   end

   assign active = active_q;
   assign level  = level_q;
   assign clkpos = clkpos_q;
   assign clkneg = clkneg_q;

endmodule

// File: rtl/adiabatic_pclk_gen.sv
// Multi-phase trapezoidal power-clock sequencer for the adiabatic gate rows.
// Define ADIABATIC_PCLK_GEN_STATS_EN to add the saturating frame_cnt output.
module adiabatic_pclk_gen
   import adiabatic_pkg::*;
#(
   parameter int unsigned N_PHASES = 4,
   parameter int unsigned LEVEL_W  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        run,
`ifdef ADIABATIC_PCLK_GEN_STATS_EN
   output logic [15:0]                 frame_cnt,
`endif
   output logic [N_PHASES*LEVEL_W-1:0] level,
   output logic [N_PHASES-1:0]         clkpos,
   output logic [N_PHASES-1:0]         clkneg,
   output logic                        busy,
   output logic                        frame_done
);

   localparam logic [LEVEL_W-1:0] MaxLvl = LEVEL_W'(level_max(LEVEL_W));
   localparam int unsigned        CtrW   = LEVEL_W + IntvW;

   pclk_state_e        state_q, state_d;
   logic [LEVEL_W-1:0] sub_q, sub_d;
   logic [IntvW-1:0]   intv_q, intv_d;
   logic               frame_done_q, frame_done_d;

   logic [CtrW-1:0]     ctr_inc;
   logic                frame_wrap;
   logic                all_idle;
   logic                phase_drain;
   logic [N_PHASES-1:0] active;

   // sub and intv form one counter: intv advances when sub wraps.
   assign ctr_inc     = {intv_q, sub_q} + CtrW'(1);
   assign frame_wrap  = (sub_q == MaxLvl) && (intv_q == IntvW'(3));
   assign all_idle    = (active == '0);
   assign phase_drain = (state_q != RUN);

   always_comb begin
      state_d      = state_q;
      sub_d        = sub_q;
      intv_d       = intv_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         STOPPED: begin
            sub_d  = '0;
            intv_d = '0;
            if (run) begin
               state_d = RUN;
            end
         end
         RUN: begin
            {intv_d, sub_d} = ctr_inc;
            if (frame_wrap) begin
               frame_done_d = 1'b1;
               if (!run) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (all_idle) begin
               state_d = STOPPED;
               sub_d   = '0;
               intv_d  = '0;
            end else begin
               {intv_d, sub_d} = ctr_inc;
            end
         end
         default: begin
            state_d = STOPPED;
            sub_d   = '0;
            intv_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= STOPPED;
         sub_q        <= '0;
         intv_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sub_q        <= sub_d;
         intv_q       <= intv_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign busy       = (state_q != STOPPED);
   assign frame_done = frame_done_q;

   for (genvar i = 0; i < N_PHASES; i++) begin : g_phase
      interval_e p_i;
      // Phase i lags phase i-1 by one interval (mod 4 arithmetic on intv).
      assign p_i = interval_e'(intv_q - IntvW'(i));

      adiabatic_pclk_phase #(
         .LEVEL_W(LEVEL_W)
      ) u_phase (
         .clk    (clk),
         .rst    (rst),
         .sub    (sub_q),
         .p_i    (p_i),
         .drain  (phase_drain),
         .active (active[i]),
         .level  (level[i*LEVEL_W +: LEVEL_W]),
         .clkpos (clkpos[i]),
         .clkneg (clkneg[i])
      );
   end

`ifdef ADIABATIC_PCLK_GEN_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_done_d && (frame_cnt_q != 16'hFFFF)) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Randomized scoreboard bench for adiabatic_pclk_gen against a frame-position model.
module tb_adiabatic_pclk_gen;

   localparam int NP    = 4;
   localparam int LW    = 3;
   localparam int INTV  = 1 << LW;
   localparam int FRAME = 4 * INTV;
   localparam int MAXL  = INTV - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             run = 1'b0;
   logic [NP*LW-1:0] level;
   logic [NP-1:0]    clkpos;
   logic [NP-1:0]    clkneg;
   logic             busy;
   logic             frame_done;
`ifdef ADIABATIC_PCLK_GEN_STATS_EN
   logic [15:0]      frame_cnt;
`endif

   adiabatic_pclk_gen #(
      .N_PHASES(NP),
      .LEVEL_W (LW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
`ifdef ADIABATIC_PCLK_GEN_STATS_EN
      .frame_cnt  (frame_cnt),
`endif
      .level      (level),
      .clkpos     (clkpos),
      .clkneg     (clkneg),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NP*LW-1:0] level;
      logic [NP-1:0]    pos;
      logic [NP-1:0]    neg;
      logic             busy;
      logic             fd;
      logic [15:0]      cnt;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   failures  = 0;
   int   rst_epoch = 0;

   // Model: mode 0 stopped, 1 run, 2 drain; m_t is the position inside the frame.
   int   m_mode = 0;
   int   m_t    = 0;
   bit   m_act[NP];
   int   m_cnt  = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s @%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic model_step(input bit r, output exp_t e);
      bit nact[NP];
      bit any_act;
      int pos, iv, s, l;
      e = '{default: '0};
      if (r) begin
         m_mode = 0;
         m_t    = 0;
         m_cnt  = 0;
         for (int i = 0; i < NP; i++) m_act[i] = 1'b0;
         return;
      end
      any_act = 1'b0;
      for (int i = 0; i < NP; i++) begin
         any_act = any_act | m_act[i];
         pos = ((m_t - i * INTV) % FRAME + FRAME) % FRAME;
         iv  = pos / INTV;
         s   = pos % INTV;
         case (iv)
            0:       l = s;
            1:       l = MAXL;
            2:       l = MAXL - s;
            default: l = 0;
         endcase
         nact[i] = m_act[i];
         if (m_mode == 1 && iv == 0) nact[i] = 1'b1;
         if (m_mode != 1 && (iv == 0 || iv == 3)) nact[i] = 1'b0;
         if (nact[i]) begin
            e.level[i*LW +: LW] = LW'(l);
            e.pos[i] = (l >= INTV / 2);
            e.neg[i] = (l < INTV / 2);
         end
      end
      e.fd = (m_mode == 1 && m_t == FRAME - 1);
      case (m_mode)
         0: if (run) m_mode = 1;
         1: begin
            m_t = (m_t + 1) % FRAME;
            if (e.fd && !run) m_mode = 2;
         end
         default: begin
            if (!any_act) begin
               m_mode = 0;
               m_t    = 0;
            end else begin
               m_t = (m_t + 1) % FRAME;
            end
         end
      endcase
      for (int i = 0; i < NP; i++) m_act[i] = nact[i];
      if (e.fd && m_cnt < 65535) m_cnt++;
      e.busy = (m_mode != 0);
      e.cnt  = 16'(m_cnt);
   endtask

   task automatic step();
      exp_t e;
      model_step(rst, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input bit chk_hold);
      @(negedge clk);
      #1;
      if (chk_hold) chk("pre_rst_phase1_hold", 64'(level[LW +: LW]), 64'(MAXL));
      rst = 1'b1;
      rst_epoch++;
      #1;
      chk("rst_async_level", 64'(level), 64'd0);
      chk("rst_async_clkpos", 64'(clkpos), 64'd0);
      chk("rst_async_clkneg", 64'(clkneg), 64'd0);
      chk("rst_async_busy", 64'(busy), 64'd0);
      step();
      rst = 1'b0;
   endtask

   // Monitor: one expected entry per clock, compared away from the active edge.
   initial begin : monitor
      exp_t e;
      int   prev_lv[NP];
      bit   prev_ok = 1'b0;
      int   seen_epoch = 0;
      int   cur, d;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("level", 64'(level), 64'(e.level));
            chk("clkpos", 64'(clkpos), 64'(e.pos));
            chk("clkneg", 64'(clkneg), 64'(e.neg));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("frame_done", 64'(frame_done), 64'(e.fd));
`ifdef ADIABATIC_PCLK_GEN_STATS_EN
            chk("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
`endif
            for (int i = 0; i < NP; i++) begin
               cur = int'(level[i*LW +: LW]);
               if (prev_ok && seen_epoch == rst_epoch && !rst) begin
                  d = (cur > prev_lv[i]) ? cur - prev_lv[i] : prev_lv[i] - cur;
                  chk("level_step_le1", 64'(d <= 1), 64'd1);
               end
               prev_lv[i] = cur;
            end
            prev_ok    = 1'b1;
            seen_epoch = rst_epoch;
         end
      end
   end

   initial begin : stimulus
      #1;
      rst = 1'b1;
      rst_epoch++;
      repeat (3) step();
      rst = 1'b0;

      // Start-up and steady run over several frames.
      run = 1'b1;
      repeat (3 * FRAME + 6) step();

      // Drop run mid-frame, let the block drain to a stop.
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         if (m_mode == 1 && m_t == 10) break;
      end
      run = 1'b0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         step();
         if (m_mode == 0) break;
      end
      repeat (4) step();

      // Request run again while draining.
      run = 1'b1;
      repeat (FRAME + 10) step();
      run = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         if (m_mode == 2) break;
      end
      repeat (3) step();
      run = 1'b1;
      repeat (2 * FRAME) step();

      // Reset while phase 1 holds its maximum level.
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         if (m_mode == 1 && m_t == 2 * INTV + 4) break;
      end
      apply_reset(1'b1);
      repeat (FRAME) step();

      // Random run toggling with occasional resets.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 39) == 0) run = ~run;
         if ($urandom_range(0, 499) == 0) apply_reset(1'b0);
         else step();
      end

`ifdef ADIABATIC_PCLK_GEN_STATS_EN
      apply_reset(1'b0);
      run = 1'b1;
      for (int k = 0; k < 6 * FRAME + 10; k++) begin
         step();
         if (m_cnt == 5) break;
      end
      chk("frame_cnt_five", 64'(frame_cnt), 64'd5);
      apply_reset(1'b0);
      chk("frame_cnt_after_rst", 64'(frame_cnt), 64'd0);
`endif

      run = 1'b0;
      repeat (3) step();
      @(negedge clk);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
